com_bus_arbiter_n: RTL
======================

COM_BUS_ARBITER_N -- requirements
Module: com_bus_arbiter_n

Interface
REQ-001 Parameter CORES, default 4: number of cores; legal range 2..8.
REQ-002 Parameter HOLD_MAX, default 16: maximum grant tenure in cycles; legal range 2..255.
REQ-003 Localparam IDX_W = max(1, clog2(CORES)).
REQ-004 Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 Com_Bus_Req_proc  input  CORES  per-core processor-side bus request, level, held until done.
REQ-008 Com_Bus_Req_snoop  input  CORES  per-core snoop-side (data supply) request, level.
REQ-009 Mem_snoop_req  input  1  lower-level memory bus request, level.
REQ-010 Com_Bus_Gnt_proc  output  CORES  processor-side grant, one-hot or zero.
REQ-011 Com_Bus_Gnt_snoop  output  CORES  snoop-side grant, one-hot or zero.
REQ-012 Mem_snoop_gnt  output  1  memory grant.
REQ-013 Bus_busy  output  1  high whenever any grant is high.
REQ-014 Gnt_idx  output  IDX_W  core index of the current proc/snoop holder; 0 when idle or memory holds.
REQ-015 Hold_timeout  output  1  one-cycle pulse when a holder is force-released.

Function
REQ-016 All outputs SHALL be registered; at most one grant bit across all three grant outputs SHALL be high in any cycle.
REQ-017 FSM states SHALL be IDLE and GRANT; a holder-class register (PROC, SNOOP, MEM) and holder index SHALL qualify GRANT.
REQ-018 IDLE: at a rising edge with any unmasked request high, the winner's grant SHALL rise at that edge (1-cycle request-to-grant latency) and the FSM SHALL enter GRANT.
REQ-019 Priority: any snoop request > Mem_snoop_req > any proc request.
REQ-020 Among snoop requests, the lowest index SHALL win.
REQ-021 Among proc requests, round-robin SHALL apply: search starts at rr_ptr and wraps from CORES-1 to 0; rr_ptr resets to 0.
REQ-022 When a proc grant to core i ends, rr_ptr SHALL become (i+1) mod CORES; snoop and memory grants SHALL NOT change rr_ptr.
REQ-023 GRANT: the grant SHALL hold while the holder's request is high; grants SHALL be non-preemptive, and higher-priority requests SHALL wait.
REQ-024 At the edge where the holder's request is sampled low, all grants SHALL clear and the FSM SHALL return to IDLE; this gives exactly one idle turnaround cycle before the next grant.
REQ-025 A tenure counter SHALL reset to 1 on grant and increment each GRANT cycle.
REQ-026 If the counter equals HOLD_MAX and the request is still high, the arbiter SHALL clear the grant, pulse Hold_timeout for one cycle, and go to IDLE.
REQ-027 The timed-out requester SHALL be masked from arbitration until its request is sampled low once.
REQ-028 Release and timeout on the same edge SHALL be treated as a normal release, with no pulse.
REQ-029 Requests dropped before being granted SHALL be ignored; there is no request latching.
REQ-030 The arbiter SHALL NOT hang with no requests: IDLE with no requests SHALL stay IDLE with all grants low.

Reset
REQ-031 rst_n low SHALL immediately clear all grants, Bus_busy, Gnt_idx, Hold_timeout, rr_ptr, the counter and the masks, and force IDLE.
REQ-032 Reset asserted mid-tenure SHALL drop the grant with no Hold_timeout pulse.
REQ-033 After rst_n deasserts, the first arbitration SHALL occur at the first rising edge at which rst_n is sampled high.

Verification (CORES=4, HOLD_MAX=8)
REQ-034 Proc requests 0,1,2,3 all held, each dropped 3 cycles after its grant -> grants in order 0,1,2,3,0, with one idle cycle between each; Gnt_idx tracks the holder.
REQ-035 Core 2 holds a proc grant while Com_Bus_Req_snoop=4'b1010 and Mem_snoop_req=1 -> after core 2 releases, snoop grant to core 1, then core 3, then memory; no preemption of core 2.
REQ-036 Core 0 holds its proc request for 20 cycles -> its grant drops after 8 cycles and Hold_timeout pulses once; core 1's pending request is granted 2 edges later; core 0 is not regranted until its request toggles low.
REQ-037 rst_n pulsed low while Com_Bus_Gnt_snoop=4'b0100 -> all outputs are 0 asynchronously; after release, with requests still high, the snoop grant re-issues at the first sampled edge and rr_ptr=0.
REQ-038 Random request stress for 10k cycles with CORES=8 -> one-hot-or-zero grant check and Bus_busy consistency hold every cycle, and no requester is starved beyond 8×(HOLD_MAX+1) cycles.

Source files
------------

// File: rtl/com_bus_arbiter_n.sv
// Shared coherence-bus arbiter: snoop > memory > processor priority, non-preemptive
// tenures bounded by HOLD_MAX, round-robin among processor requests.
module com_bus_arbiter_n #(
    parameter int CORES    = 4,
    parameter int HOLD_MAX = 16,
    localparam int IDX_W   = (CORES > 1) ? $clog2(CORES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CORES-1:0] Com_Bus_Req_proc,
    input  logic [CORES-1:0] Com_Bus_Req_snoop,
    input  logic             Mem_snoop_req,
    output logic [CORES-1:0] Com_Bus_Gnt_proc,
    output logic [CORES-1:0] Com_Bus_Gnt_snoop,
    output logic             Mem_snoop_gnt,
    output logic             Bus_busy,
    output logic [IDX_W-1:0] Gnt_idx,
    output logic             Hold_timeout
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

    typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
    typedef enum logic [1:0] {HC_PROC = 2'd0, HC_SNOOP = 2'd1, HC_MEM = 2'd2} holder_t;

    state_t           state_r, state_s;
    holder_t          holder_r, holder_s;
    logic [IDX_W-1:0] hidx_r, hidx_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [IDX_W-1:0] rr_r, rr_s;
    logic [CORES-1:0] mask_proc_r, mask_proc_s;
    logic [CORES-1:0] mask_snoop_r, mask_snoop_s;
    logic             mask_mem_r, mask_mem_s;
    logic [CORES-1:0] gnt_proc_r, gnt_proc_s;
    logic [CORES-1:0] gnt_snoop_r, gnt_snoop_s;
    logic             gnt_mem_r, gnt_mem_s;
    logic             busy_r, busy_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic             tmo_r, tmo_s;

    logic [CORES-1:0] proc_ok_s, snoop_ok_s;
    logic             mem_ok_s, holder_req_s;
    logic [IDX_W-1:0] snoop_win_s, proc_win_s, rr_next_s;

    function automatic logic [CORES-1:0] onehot(input logic [IDX_W-1:0] idx);
        for (int i = 0; i < CORES; i++) begin
            onehot[i] = (idx == IDX_W'(i));
        end
    endfunction

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [CORES-1:0] v);
        lowest_idx = {IDX_W{1'b0}};
        for (int i = CORES - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

    // Rotate the request vector so the search starts at ptr, then map back modulo CORES.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [CORES-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [2*CORES-1:0] rot;
        logic [IDX_W:0]     pos;
        logic               found;
        rot     = {req, req} >> ptr;
        rr_pick = {IDX_W{1'b0}};
        found   = 1'b0;
        for (int k = 0; k < CORES; k++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(CORES)) pos = pos - (IDX_W+1)'(CORES);
            if (!found && rot[k]) begin
                rr_pick = pos[IDX_W-1:0];
                found   = 1'b1;
            end
        end
    endfunction

    // Eligible requests, winners and the current holder's request level.
    always_comb begin
        proc_ok_s   = Com_Bus_Req_proc & ~mask_proc_r;
        snoop_ok_s  = Com_Bus_Req_snoop & ~mask_snoop_r;
        mem_ok_s    = Mem_snoop_req & ~mask_mem_r;
        snoop_win_s = lowest_idx(snoop_ok_s);
        proc_win_s  = rr_pick(proc_ok_s, rr_r);
        rr_next_s   = (hidx_r == IDX_W'(CORES - 1)) ? {IDX_W{1'b0}} : hidx_r + IDX_W'(1);
        case (holder_r)
            HC_PROC:  holder_req_s = Com_Bus_Req_proc[hidx_r];
            HC_SNOOP: holder_req_s = Com_Bus_Req_snoop[hidx_r];
            HC_MEM:   holder_req_s = Mem_snoop_req;
            default:  holder_req_s = 1'b0;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_s      = state_r;
        holder_s     = holder_r;
        hidx_s       = hidx_r;
        cnt_s        = cnt_r;
        rr_s         = rr_r;
        mask_proc_s  = mask_proc_r & Com_Bus_Req_proc;
        mask_snoop_s = mask_snoop_r & Com_Bus_Req_snoop;
        mask_mem_s   = mask_mem_r & Mem_snoop_req;
        gnt_proc_s   = {CORES{1'b0}};
        gnt_snoop_s  = {CORES{1'b0}};
        gnt_mem_s    = 1'b0;
        busy_s       = 1'b0;
        idx_s        = {IDX_W{1'b0}};
        tmo_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|snoop_ok_s) begin
                    state_s     = ST_GRANT;
                    holder_s    = HC_SNOOP;
                    hidx_s      = snoop_win_s;
                    cnt_s       = CNT_W'(1);
                    gnt_snoop_s = onehot(snoop_win_s);
                    busy_s      = 1'b1;
                    idx_s       = snoop_win_s;
                end else if (mem_ok_s) begin
                    state_s   = ST_GRANT;
                    holder_s  = HC_MEM;
                    hidx_s    = {IDX_W{1'b0}};
                    cnt_s     = CNT_W'(1);
                    gnt_mem_s = 1'b1;
                    busy_s    = 1'b1;
                end else if (|proc_ok_s) begin
                    state_s    = ST_GRANT;
                    holder_s   = HC_PROC;
                    hidx_s     = proc_win_s;
                    cnt_s      = CNT_W'(1);
                    gnt_proc_s = onehot(proc_win_s);
                    busy_s     = 1'b1;
                    idx_s      = proc_win_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!holder_req_s || (cnt_r == HOLD_LIM)) begin
                    // A request still high here means the tenure expired rather than ended.
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                    tmo_s   = holder_req_s;
                    if (holder_req_s) begin
                        case (holder_r)
                            HC_PROC:  mask_proc_s  = mask_proc_s | onehot(hidx_r);
                            HC_SNOOP: mask_snoop_s = mask_snoop_s | onehot(hidx_r);
                            HC_MEM:   mask_mem_s   = 1'b1;
                            default:  mask_mem_s   = mask_mem_s;
                        endcase
                    end else begin
                        mask_mem_s = mask_mem_s;
                    end
                    if (holder_r == HC_PROC) begin
                        rr_s = rr_next_s;
                    end else begin
                        rr_s = rr_r;
                    end
                end else begin
                    cnt_s       = cnt_r + CNT_W'(1);
                    gnt_proc_s  = gnt_proc_r;
                    gnt_snoop_s = gnt_snoop_r;
                    gnt_mem_s   = gnt_mem_r;
                    busy_s      = busy_r;
                    idx_s       = idx_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            holder_r     <= HC_PROC;
            hidx_r       <= {IDX_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            rr_r         <= {IDX_W{1'b0}};
            mask_proc_r  <= {CORES{1'b0}};
            mask_snoop_r <= {CORES{1'b0}};
            mask_mem_r   <= 1'b0;
            gnt_proc_r   <= {CORES{1'b0}};
            gnt_snoop_r  <= {CORES{1'b0}};
            gnt_mem_r    <= 1'b0;
            busy_r       <= 1'b0;
            idx_r        <= {IDX_W{1'b0}};
            tmo_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            holder_r     <= holder_s;
            hidx_r       <= hidx_s;
            cnt_r        <= cnt_s;
            rr_r         <= rr_s;
            mask_proc_r  <= mask_proc_s;
            mask_snoop_r <= mask_snoop_s;
            mask_mem_r   <= mask_mem_s;
            gnt_proc_r   <= gnt_proc_s;
            gnt_snoop_r  <= gnt_snoop_s;
            gnt_mem_r    <= gnt_mem_s;
            busy_r       <= busy_s;
            idx_r        <= idx_s;
            tmo_r        <= tmo_s;
        end
    end

    assign Com_Bus_Gnt_proc  = gnt_proc_r;
    assign Com_Bus_Gnt_snoop = gnt_snoop_r;
    assign Mem_snoop_gnt     = gnt_mem_r;
    assign Bus_busy          = busy_r;
    assign Gnt_idx           = idx_r;
    assign Hold_timeout      = tmo_r;

endmodule
